// File: rtl/rbcp_reg_readback.sv
// RBCP read responder: fetches 32-bit words from a register source, caches the last word,
// and returns bytes MSB-first with a timeout fallback so every read is acknowledged.
module rbcp_reg_readback #(
  parameter int unsigned TIMEOUT      = 255,
  parameter logic [7:0]  TIMEOUT_BYTE = 8'hEE
) (
  input  logic        sitcp_user_clk,
  input  logic        rst_n,
  input  logic        RBCP_ACT,
  input  logic [31:0] RBCP_ADDR,
  input  logic        RBCP_WE,
  input  logic        RBCP_RE,
  output logic [7:0]  RBCP_RD,
  output logic        RBCP_ACK,
  output logic        reg_rd_req,
  output logic [31:0] reg_rd_addr,
  input  logic [31:0] reg_rd_data,
  input  logic        reg_rd_valid,
  output logic [15:0] rd_err_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_ACK  = 2'd3;

  // WAIT is entered with the counter at 0, so the last waiting cycle is TIMEOUT-1
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [31:0] cache_word;
  logic [29:0] cache_addr;
  logic        cache_vld;
  logic [1:0]  byte_sel;
  logic [7:0]  to_cnt;
  logic        hit;

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  // A read coinciding with a write must not be served from a possibly stale cache
  assign hit = cache_vld && (cache_addr == RBCP_ADDR[31:2]) && !RBCP_WE;

  always_ff @(posedge sitcp_user_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      RBCP_RD     <= '0;
      RBCP_ACK    <= 1'b0;
      reg_rd_req  <= 1'b0;
      reg_rd_addr <= '0;
      rd_err_cnt  <= '0;
      cache_word  <= '0;
      cache_addr  <= '0;
      cache_vld   <= 1'b0;
      byte_sel    <= '0;
      to_cnt      <= '0;
    end else begin
      RBCP_ACK   <= 1'b0;
      reg_rd_req <= 1'b0;
      case (state)
        S_IDLE: begin
          if (RBCP_RE) begin
            if (hit) begin
              RBCP_RD  <= pick_byte(cache_word, RBCP_ADDR[1:0]);
              RBCP_ACK <= 1'b1;
              state    <= S_ACK;
            end else begin
              // request is registered here so it is high during the REQ cycle
              reg_rd_addr <= {RBCP_ADDR[31:2], 2'b00};
              byte_sel    <= RBCP_ADDR[1:0];
              reg_rd_req  <= 1'b1;
              state       <= S_REQ;
            end
          end
        end
        S_REQ: begin
          to_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (reg_rd_valid) begin
            cache_word <= reg_rd_data;
            cache_addr <= reg_rd_addr[31:2];
            cache_vld  <= 1'b1;
            RBCP_RD    <= pick_byte(reg_rd_data, byte_sel);
            RBCP_ACK   <= 1'b1;
            state      <= S_ACK;
          end else if (to_cnt == TO_LAST) begin
            RBCP_RD   <= TIMEOUT_BYTE;
            RBCP_ACK  <= 1'b1;
            cache_vld <= 1'b0;
            if (rd_err_cnt != 16'hFFFF) rd_err_cnt <= rd_err_cnt + 16'd1;
            state     <= S_ACK;
          end else if (!RBCP_ACT) begin
            state <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
      // invalidation overrides any load in the same cycle
      if (RBCP_WE || !RBCP_ACT) cache_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rbcp_reg_readback.sv
// Self-checking bench for rbcp_reg_readback: directed table, corner sequences,
// and randomized reads against a word-level cache model.
module tb_rbcp_reg_readback;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        act = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [7:0]  rd;
  logic        ack;
  logic        req;
  logic [31:0] req_addr_o;
  logic [31:0] src_data = '0;
  logic        src_valid = 1'b0;
  logic [15:0] err_cnt;

  rbcp_reg_readback #(.TIMEOUT(TO), .TIMEOUT_BYTE(8'hEE)) dut (
    .sitcp_user_clk(clk),
    .rst_n(rst_n),
    .RBCP_ACT(act),
    .RBCP_ADDR(addr),
    .RBCP_WE(we),
    .RBCP_RE(re),
    .RBCP_RD(rd),
    .RBCP_ACK(ack),
    .reg_rd_req(req),
    .reg_rd_addr(req_addr_o),
    .reg_rd_data(src_data),
    .reg_rd_valid(src_valid),
    .rd_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: last fetched word, its address, and the error tally
  logic        m_vld = 1'b0;
  logic [29:0] m_addr = '0;
  logic [31:0] m_word = '0;
  int          m_err = 0;

  task automatic model_read(input logic [31:0] a, input int k, input logic [31:0] w,
                            output logic [7:0] e_rd, output int e_lat, output int e_nreq);
    int sh;
    sh = 8 * (3 - int'(a[1:0]));
    if (m_vld && m_addr == a[31:2]) begin
      e_nreq = 0; e_lat = 1; e_rd = 8'((m_word >> sh) & 32'hFF);
    end else begin
      e_nreq = 1;
      if (k >= 1 && k <= TO) begin
        e_lat = 2 + k; e_rd = 8'((w >> sh) & 32'hFF);
        m_vld = 1'b1; m_addr = a[31:2]; m_word = w;
      end else begin
        e_lat = 2 + TO; e_rd = 8'hEE; m_vld = 1'b0;
        if (m_err < 65535) m_err++;
      end
    end
  endtask

  // Issues one byte read; the source answers k cycles after the request (k=0: never)
  task automatic do_read(input logic [31:0] a, input int k, input logic [31:0] w,
                         output logic [7:0] g_rd, output int g_lat, output int g_nreq,
                         output logic [31:0] g_raddr);
    int req_c;
    g_lat = -1; g_nreq = 0; g_rd = '0; g_raddr = '0; req_c = -1;
    @(posedge clk); #1 re = 1'b1; addr = a;
    @(posedge clk); #1 re = 1'b0;
    for (int c = 1; c < 300; c++) begin
      src_valid = 1'b0;
      if (req) begin g_nreq++; g_raddr = req_addr_o; req_c = c; end
      if (ack) begin g_rd = rd; g_lat = c; break; end
      if (k > 0 && req_c > 0 && c == req_c + k) begin src_valid = 1'b1; src_data = w; end
      @(posedge clk); #1;
    end
    src_valid = 1'b0;
  endtask

  task automatic pulse_we(input logic [31:0] a);
    @(posedge clk); #1 we = 1'b1; addr = a;
    @(posedge clk); #1 we = 1'b0;
    m_vld = 1'b0;
  endtask

  task automatic drop_act();
    @(posedge clk); #1 act = 1'b0;
    @(posedge clk); #1 act = 1'b1;
    m_vld = 1'b0;
  endtask

  task automatic pre_op(input int op, input logic [31:0] a);
    if (op == 1) pulse_we(a);
    else if (op == 2) drop_act();
  endtask

  typedef struct {
    int          op;   // 0 none, 1 write before read, 2 ACT drop before read
    logic [31:0] a;
    int          k;
    logic [31:0] w;
    logic [7:0]  exp_rd;
    int          exp_lat;
    int          exp_nreq;
    logic [15:0] exp_err;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [7:0]  g_rd, e_rd;
    int          g_lat, g_nreq, e_lat, e_nreq, acks;
    logic [31:0] g_raddr;

    tbl[0] = '{0, 32'h10, 3, 32'h11223344, 8'h11, 5,  1, 16'd0};
    tbl[1] = '{0, 32'h11, 3, 32'h0,        8'h22, 1,  0, 16'd0};
    tbl[2] = '{0, 32'h12, 3, 32'h0,        8'h33, 1,  0, 16'd0};
    tbl[3] = '{0, 32'h13, 3, 32'h0,        8'h44, 1,  0, 16'd0};
    tbl[4] = '{1, 32'h11, 2, 32'h11223344, 8'h22, 4,  1, 16'd0};
    tbl[5] = '{0, 32'h20, 0, 32'h0,        8'hEE, 10, 1, 16'd1};
    tbl[6] = '{0, 32'h20, 8, 32'hCAFEBABE, 8'hCA, 10, 1, 16'd1};
    tbl[7] = '{0, 32'h23, 1, 32'h0,        8'hBE, 1,  0, 16'd1};
    tbl[8] = '{2, 32'h22, 1, 32'h01020304, 8'h03, 3,  1, 16'd1};

    #12;
    chk("reset_rd", 32'(rd), 32'h0);
    chk("reset_ack", 32'(ack), 32'h0);
    chk("reset_req", 32'(req), 32'h0);
    chk("reset_raddr", req_addr_o, 32'h0);
    chk("reset_err", 32'(err_cnt), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1; act = 1'b1;

    foreach (tbl[i]) begin
      pre_op(tbl[i].op, tbl[i].a);
      do_read(tbl[i].a, tbl[i].k, tbl[i].w, g_rd, g_lat, g_nreq, g_raddr);
      model_read(tbl[i].a, tbl[i].k, tbl[i].w, e_rd, e_lat, e_nreq);
      chk($sformatf("tbl%0d_rd", i), 32'(g_rd), 32'(tbl[i].exp_rd));
      chk($sformatf("tbl%0d_lat", i), g_lat, tbl[i].exp_lat);
      chk($sformatf("tbl%0d_nreq", i), g_nreq, tbl[i].exp_nreq);
      chk($sformatf("tbl%0d_err", i), 32'(err_cnt), 32'(tbl[i].exp_err));
      if (tbl[i].exp_nreq > 0)
        chk($sformatf("tbl%0d_raddr", i), g_raddr, {tbl[i].a[31:2], 2'b00});
    end

    // ACT drops during WAIT, then a late valid: no ACK, next read misses
    @(posedge clk); #1 re = 1'b1; addr = 32'h30;
    @(posedge clk); #1 re = 1'b0;
    @(posedge clk); #1 act = 1'b0;
    @(posedge clk); #1 act = 1'b1; src_valid = 1'b1; src_data = 32'hDEADBEEF;
    acks = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1 src_valid = 1'b0;
      if (ack) acks++;
    end
    chk("abort_no_ack", acks, 0);
    m_vld = 1'b0;
    do_read(32'h30, 1, 32'h5A6B7C8D, g_rd, g_lat, g_nreq, g_raddr);
    model_read(32'h30, 1, 32'h5A6B7C8D, e_rd, e_lat, e_nreq);
    chk("abort_next_nreq", g_nreq, 1);
    chk("abort_next_rd", 32'(g_rd), 32'h5A);

    // Stray valid in IDLE must not disturb the cached word
    @(posedge clk); #1 src_valid = 1'b1; src_data = 32'h99999999;
    @(posedge clk); #1 src_valid = 1'b0;
    chk("stray_no_ack", 32'(ack), 32'h0);
    do_read(32'h31, 1, 32'h0, g_rd, g_lat, g_nreq, g_raddr);
    model_read(32'h31, 1, 32'h0, e_rd, e_lat, e_nreq);
    chk("stray_hit_rd", 32'(g_rd), 32'(e_rd));
    chk("stray_hit_lat", g_lat, e_lat);

    // Randomized reads against the model
    for (int i = 0; i < 200; i++) begin
      int op, kk;
      logic [31:0] a, w;
      op = $urandom_range(0, 9);
      op = (op == 0) ? 1 : (op == 1) ? 2 : 0;
      a  = 32'($urandom_range(0, 63));
      kk = $urandom_range(0, 12);
      w  = $urandom;
      pre_op(op, a);
      do_read(a, kk, w, g_rd, g_lat, g_nreq, g_raddr);
      model_read(a, kk, w, e_rd, e_lat, e_nreq);
      chk($sformatf("rnd%0d_rd", i), 32'(g_rd), 32'(e_rd));
      chk($sformatf("rnd%0d_lat", i), g_lat, e_lat);
      chk($sformatf("rnd%0d_nreq", i), g_nreq, e_nreq);
      chk($sformatf("rnd%0d_err", i), 32'(err_cnt), 32'(m_err));
    end

    // Reset asserted mid-WAIT clears outputs immediately; late valid afterwards ignored
    @(posedge clk); #1 re = 1'b1; addr = 32'h104;
    @(posedge clk); #1 re = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_rd", 32'(rd), 32'h0);
    chk("rst_mid_ack", 32'(ack), 32'h0);
    chk("rst_mid_req", 32'(req), 32'h0);
    chk("rst_mid_raddr", req_addr_o, 32'h0);
    chk("rst_mid_err", 32'(err_cnt), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1; src_valid = 1'b1; src_data = 32'h12345678;
    acks = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1 src_valid = 1'b0;
      if (ack) acks++;
    end
    chk("rst_late_valid_no_ack", acks, 0);
    chk("rst_late_valid_rd", 32'(rd), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
